i2s_encoder: RTL and testbench

//  I2S master transmitter: serialises stereo PCM samples onto sck/ws/sd for an external DAC or
//  a loopback into i2s_decoder. Sits downstream of the DSP chain. Upstream pushes one

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_sck_gen.sv | 38 +++
 rtl/i2s_encoder.sv | 111 +++++++++++
 tb/tb_i2s_encoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the encoder and decoder.
// Default widths, slot index type and word-select slot rule.
package i2s_pkg;

  localparam int SAMPLE_W_D = 16;
  localparam int SLOT_W_D   = 16;
  localparam int FRAME_SCK  = 2 * SLOT_W_D;
  localparam int SLOT_IW    = $clog2(FRAME_SCK);

  typedef logic [SLOT_IW-1:0] slot_t;

  // ws leads each channel's MSB by one bit period
  function automatic logic ws_of(
    input int k,
    input int slot_w
  );
    return (k >= slot_w - 1) && (k <= 2 * slot_w - 2);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divider plus sck register.
// Ticks flag the clk edge on which sck will toggle.
module i2s_sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_sck,
  output logic o_fall_tick,
  output logic o_rise_tick
);

  localparam int DW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_sck;
  logic          w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_sck <= 1'b1;
    end else if (w_wrap) begin
      r_div <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_sck       = r_sck;
  assign o_fall_tick = w_wrap & r_sck;
  assign o_rise_tick = w_wrap & ~r_sck;

endmodule

// File: rtl/i2s_encoder.sv
// I2S master transmitter (Philips format) with a one-pair
// holding register behind a valid/ready handshake.
module i2s_encoder
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_D,
  parameter int SLOT_W   = SLOT_W_D,
  parameter int SCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                sck,
  output logic                ws,
  output logic                sd,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FW = 2 * SLOT_W;
  localparam int KW = $clog2(FW);
  localparam logic [KW-1:0] K_LAST = KW'(FW - 1);

  logic          w_fall;
  logic          w_unused_rise;
  logic          w_bound;
  logic          w_xfer;
  logic [KW-1:0] w_k_nxt;
  logic [FW-1:0] w_frame;

  logic [KW-1:0]       r_k;
  logic                r_ws;
  logic                r_sd;
  logic                r_ready;
  logic                r_fs;
  logic                r_ur;
  logic [SAMPLE_W-1:0] r_hl;
  logic [SAMPLE_W-1:0] r_hr;
  logic [FW-1:0]       r_shift;

  i2s_sck_gen #(
    .SCK_DIV(SCK_DIV)
  ) u_sck (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_sck      (sck),
    .o_fall_tick(w_fall),
    .o_rise_tick(w_unused_rise)
  );

  assign w_k_nxt = (r_k == K_LAST) ? '0 : r_k + 1'b1;
  assign w_bound = w_fall && (r_k == K_LAST);
  assign w_xfer  = sample_valid && r_ready;

  // Whole frame laid out MSB-first; empty hold sends zeros
  always_comb begin
    w_frame = '0;
    if (!r_ready) begin
      w_frame[FW-1 -: SAMPLE_W]     = r_hl;
      w_frame[SLOT_W-1 -: SAMPLE_W] = r_hr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= K_LAST;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
      r_ready <= 1'b1;
      r_fs    <= 1'b0;
      r_ur    <= 1'b0;
      r_hl    <= '0;
      r_hr    <= '0;
      r_shift <= '0;
    end else begin
      r_fs <= w_bound;
      r_ur <= w_bound & r_ready;
      if (w_fall) begin
        r_k  <= w_k_nxt;
        r_ws <= ws_of(int'(w_k_nxt), SLOT_W);
        if (w_bound) begin
          r_sd    <= w_frame[FW-1];
          r_shift <= w_frame << 1;
        end else begin
          r_sd    <= r_shift[FW-1];
          r_shift <= r_shift << 1;
        end
      end
      // a transfer on an empty-hold boundary waits for the next frame
      if (w_bound && !r_ready) begin
        r_ready <= 1'b1;
        r_hl    <= '0;
        r_hr    <= '0;
      end else if (w_xfer) begin
        r_ready <= 1'b0;
        r_hl    <= left_in;
        r_hr    <= right_in;
      end
    end
  end

  assign sample_ready = r_ready;
  assign ws           = r_ws;
  assign sd           = r_sd;
  assign frame_start  = r_fs;
  assign underrun     = r_ur;

endmodule

// File: tb/tb_i2s_encoder.sv
// Self-checking bench for i2s_encoder: frames captured on rising
// sck are compared against pairs accepted before each boundary.
module tb_i2s_encoder;

  localparam int  SW   = 16;
  localparam int  SL   = 24;
  localparam int  DIV  = 4;
  localparam int  FB   = 2 * SL;
  localparam int  FCLK = FB * 2 * DIV;
  localparam time P    = FCLK * 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] left_in = '0;
  logic [SW-1:0] right_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          frame_start;
  logic          underrun;

  i2s_encoder #(
    .SAMPLE_W(SW),
    .SLOT_W  (SL),
    .SCK_DIV (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left_in     (left_in),
    .right_in    (right_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FB-1:0] sdv;
    logic [FB-1:0] wsv;
    logic          ur;
    time           t;
  } frm_t;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    time           t;
  } acc_t;

  frm_t cap_q[$];
  acc_t acc_q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  bit   in_frame = 0;
  int   bitn = 0;
  frm_t cur;
  logic prev_sck = 1'b1;
  int   run = 0;
  int   hi_len = 0;
  int   lo_len = 0;
  time  last_fb = 0;
  time  prev_fb = 0;
  bit   have_prev = 0;

  // DAC-style receiver: latch ws/sd on each rising sck
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
      prev_sck = 1'b1;
      run = 0;
    end else begin
      if (frame_start) begin
        in_frame = 1;
        bitn = 0;
        cur.sdv = '0;
        cur.wsv = '0;
        cur.ur = underrun;
        cur.t = $time - 5;
        last_fb = $time - 5;
      end
      if (in_frame && sck && !prev_sck) begin
        cur.sdv[FB-1-bitn] = sd;
        cur.wsv[FB-1-bitn] = ws;
        bitn++;
        if (bitn == FB) begin
          cap_q.push_back(cur);
          in_frame = 0;
        end
      end
      if (sck == prev_sck) run++;
      else begin
        if (prev_sck) hi_len = run;
        else lo_len = run;
        run = 1;
      end
      prev_sck = sck;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] exp_sd(input logic [SW-1:0] l,
                                           input logic [SW-1:0] r);
    logic [FB-1:0] e;
    e = '0;
    for (int b = 0; b < FB; b++) begin
      if (b < SW) e[FB-1-b] = l[SW-1-b];
      else if (b >= SL && b < SL + SW) e[FB-1-b] = r[SW-1-(b-SL)];
    end
    return e;
  endfunction

  function automatic logic [FB-1:0] exp_ws();
    logic [FB-1:0] e;
    e = '0;
    for (int b = 0; b < FB; b++)
      e[FB-1-b] = (b >= SL - 1) && (b <= 2 * SL - 2);
    return e;
  endfunction

  task automatic check_frames(input int n);
    frm_t          f;
    acc_t          a;
    logic [SW-1:0] el;
    logic [SW-1:0] er;
    logic          eu;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (cap_q.size() == 0 && w < 3 * FCLK) begin
        @(negedge clk);
        w++;
      end
      if (cap_q.size() == 0) begin
        chk("frame_timeout", 64'd0, 64'd1);
        return;
      end
      f = cap_q.pop_front();
      if (acc_q.size() > 0 && acc_q[0].t < f.t) begin
        a = acc_q.pop_front();
        el = a.l;
        er = a.r;
        eu = 1'b0;
      end else begin
        el = '0;
        er = '0;
        eu = 1'b1;
      end
      chk("underrun", 64'(f.ur), 64'(eu));
      chk("sd_frame", 64'(f.sdv), 64'(exp_sd(el, er)));
      chk("ws_frame", 64'(f.wsv), 64'(exp_ws()));
      if (have_prev) chk("frame_spacing", 64'(f.t - prev_fb), 64'(P));
      prev_fb = f.t;
      have_prev = 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (acc_q.size() == 0) break;
      check_frames(1);
    end
    chk("pending_drained", 64'(acc_q.size()), 64'd0);
  endtask

  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int w = 0;
    @(negedge clk);
    left_in = l;
    right_in = r;
    sample_valid = 1'b1;
    while (!sample_ready && w < 3 * FCLK) begin
      @(negedge clk);
      w++;
    end
    if (!sample_ready) begin
      chk("push_timeout", 64'd0, 64'd1);
      sample_valid = 1'b0;
      return;
    end
    acc_q.push_back('{l, r, $time + 5});
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic reset_check();
    int n = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outs",
        64'({sck, ws, sd, sample_ready, frame_start, underrun}),
        64'(6'b100100));
    cap_q.delete();
    acc_q.delete();
    have_prev = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (!sck) break;
    end
    chk("first_fall_clks", 64'(n), 64'(DIV));
    chk("first_boundary", 64'({frame_start, underrun}), 64'(2'b11));
  endtask

  initial begin
    time  bnd;
    int   nacc;
    logic [SW-1:0] cnt;

    reset_check();

    push(16'hA5C3, 16'h8001);
    for (int i = 0; i < 4; i++) push(SW'($urandom), SW'($urandom));
    drain();

    check_frames(3);
    chk("sck_high_clks", 64'(hi_len), 64'(DIV));
    chk("sck_low_clks", 64'(lo_len), 64'(DIV));

    nacc = 0;
    cnt = '0;
    @(negedge clk);
    left_in = cnt;
    right_in = ~cnt;
    sample_valid = 1'b1;
    for (int c = 0; c < 5 * FCLK; c++) begin
      if (sample_ready) begin
        acc_q.push_back('{left_in, right_in, $time + 5});
        nacc++;
        @(negedge clk);
        chk("ready_low_after_accept", 64'(sample_ready), 64'd0);
        cnt = cnt + 1'b1;
        left_in = cnt;
        right_in = ~cnt;
      end else begin
        @(negedge clk);
      end
    end
    sample_valid = 1'b0;
    chk("one_accept_per_frame", 64'(nacc == 5 || nacc == 6), 64'd1);
    drain();

    bnd = last_fb + P;
    while (bnd - 5 <= $time) bnd = bnd + P;
    while ($time < bnd - 5) @(negedge clk);
    chk("ready_before_boundary", 64'(sample_ready), 64'd1);
    left_in = SW'($urandom);
    right_in = SW'($urandom);
    sample_valid = 1'b1;
    acc_q.push_back('{left_in, right_in, bnd});
    @(negedge clk);
    sample_valid = 1'b0;
    drain();

    push(16'hFFFF, 16'h7FFE);
    repeat (FCLK / 3) @(negedge clk);
    reset_check();
    check_frames(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
